// File: rtl/dac_pkg.sv
// Shared constants, frame layout and FSM states for the DAC081S101 SPI write driver.
package dac_pkg;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } dac_state_t;

    // Frame as the DAC expects it: two don't-care zeros, PD bits, code, four trailing zeros.
    function automatic logic [FRAME_BITS-1:0] dac_frame(input logic [1:0] pd, input logic [7:0] code);
        return {2'b00, pd, code, 4'b0000};
    endfunction

endpackage

// File: rtl/dac081s101_driver_half_tick.sv
// Divider that emits a one-cycle tick every HALF_DIV clocks while enabled.
module spi_half_tick #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Clearing while disabled guarantees every frame starts phase-aligned.
    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dac081s101_driver.sv
// SPI write master for the DAC081S101: start/ready handshake, 16-bit MSB-first frame, SYNC-high gap.
module dac081s101_driver
    import dac_pkg::*;
#(
    parameter int HALF_DIV = 2,
    parameter int GAP_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dac_start,
    input  logic [7:0] dac_data,
    input  logic [1:0] dac_pd,
    output logic       dac_ready,
    output logic       dac_done,
    output logic       dac_sync,
    output logic       dac_sclk,
    output logic       dac_din
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    dac_state_t            state, state_d;
    logic                  sync_q, sync_d;
    logic                  sclk_q, sclk_d;
    logic                  din_q, din_d;
    logic                  done_q, done_d;
    logic [FRAME_BITS-1:0] shreg, shreg_d;
    logic [3:0]            bitcnt, bitcnt_d;
    logic [GW-1:0]         gapcnt, gapcnt_d;
    logic [FRAME_BITS-1:0] frame;
    logic                  tick;

    assign frame = dac_frame(dac_pd, dac_data);

    spi_half_tick #(.HALF_DIV(HALF_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   ((state == SETUP) || (state == SHIFT)),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sync_q <= 1'b1;
            sclk_q <= 1'b1;
            din_q  <= 1'b0;
            done_q <= 1'b0;
            shreg  <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
        end else begin
            state  <= state_d;
            sync_q <= sync_d;
            sclk_q <= sclk_d;
            din_q  <= din_d;
            done_q <= done_d;
            shreg  <= shreg_d;
            bitcnt <= bitcnt_d;
            gapcnt <= gapcnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        sync_d   = sync_q;
        sclk_d   = sclk_q;
        din_d    = din_q;
        done_d   = 1'b0;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        gapcnt_d = gapcnt;
        case (state)
            IDLE: begin
                if (dac_start) begin
                    state_d  = SETUP;
                    sync_d   = 1'b0;
                    sclk_d   = 1'b1;
                    shreg_d  = frame;
                    din_d    = frame[FRAME_BITS-1];
                    bitcnt_d = 4'(FRAME_BITS - 1);
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        // Rising edge: DAC already took this bit on the fall, present the next one.
                        sclk_d  = 1'b1;
                        din_d   = shreg[FRAME_BITS-2];
                        shreg_d = {shreg[FRAME_BITS-2:0], 1'b0};
                    end else if (bitcnt == 4'd0) begin
                        state_d  = GAP;
                        sync_d   = 1'b1;
                        din_d    = 1'b0;
                        done_d   = 1'b1;
                        gapcnt_d = '0;
                    end else begin
                        sclk_d   = 1'b0;
                        bitcnt_d = bitcnt - 4'd1;
                    end
                end
            end
            GAP: begin
                if (gapcnt == GAP_LAST)
                    state_d = IDLE;
                else
                    gapcnt_d = gapcnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dac_ready = (state == IDLE);
    assign dac_done  = done_q;
    assign dac_sync  = sync_q;
    assign dac_sclk  = sclk_q;
    assign dac_din   = din_q;

endmodule

// File: tb/tb_dac081s101_driver.sv
// Bench for dac081s101_driver: instance 0 at defaults (HALF_DIV=2, GAP_CYC=4), instance 1 at HALF_DIV=1, GAP_CYC=1.
module tb_dac081s101_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic [7:0] data  [2];
    logic [1:0] pd    [2];
    logic       ready [2];
    logic       done  [2];
    logic       sync  [2];
    logic       sclk  [2];
    logic       din   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac081s101_driver #(.HALF_DIV(2), .GAP_CYC(4)) u0 (
        .clk(clk), .rst(rst), .dac_start(start[0]), .dac_data(data[0]), .dac_pd(pd[0]),
        .dac_ready(ready[0]), .dac_done(done[0]), .dac_sync(sync[0]), .dac_sclk(sclk[0]), .dac_din(din[0])
    );

    dac081s101_driver #(.HALF_DIV(1), .GAP_CYC(1)) u1 (
        .clk(clk), .rst(rst), .dac_start(start[1]), .dac_data(data[1]), .dac_pd(pd[1]),
        .dac_ready(ready[1]), .dac_done(done[1]), .dac_sync(sync[1]), .dac_sclk(sclk[1]), .dac_din(din[1])
    );

    function automatic int hd(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int gc(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int k, input string name);
        logic [4:0] got;
        got = {sync[k], sclk[k], din[k], ready[k], done[k]};
        checks++;
        if (got !== 5'b11010) begin
            errors++;
            $display("FAIL %s[%0d]: {sync,sclk,din,ready,done} got %b expected 11010", name, k, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            data[k]  = 8'h00;
            pd[k]    = 2'b00;
        end
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            for (int k = 0; k < 2; k++) check_idle(k, "reset_idle");
        end
    endtask

    // One frame on instance k; optionally pulses start while busy or scrambles the inputs mid-frame.
    task automatic run_frame(input int k, input logic [7:0] d, input logic [1:0] p,
                             input bit busy_pulse, input bit mid_change, input string name);
        logic [15:0] exp_w, cap;
        int falls, low, dones, done_at, lat, stray, cyc, extra_bad;
        logic prev_sclk;
        exp_w = {2'b00, p, d, 4'b0000};
        cap = '0; falls = 0; low = 0; dones = 0; done_at = -1; lat = -1; stray = 0; cyc = 0;
        data[k] = d; pd[k] = p; start[k] = 1'b1;
        prev_sclk = sclk[k];
        while (lat < 0 && cyc < 300) begin
            step();
            cyc++;
            start[k] = busy_pulse && (cyc == 20 || cyc == 33 * hd(k) + 1);
            if (mid_change && cyc == 3) begin
                data[k] = ~d;
                pd[k]   = ~p;
            end
            if (sync[k] === 1'b0) begin
                low++;
                if (prev_sclk === 1'b1 && sclk[k] === 1'b0) begin
                    cap = {cap[14:0], din[k]};
                    falls++;
                end
            end else if (sclk[k] !== prev_sclk) begin
                stray++;
            end
            if (done[k] === 1'b1) begin
                dones++;
                done_at = cyc;
            end
            if (ready[k] === 1'b1) lat = cyc;
            prev_sclk = sclk[k];
        end
        start[k] = 1'b0;
        checks++; if (cap !== exp_w) begin errors++; $display("FAIL %s word: got %h expected %h", name, cap, exp_w); end
        checks++; if (falls != 16) begin errors++; $display("FAIL %s falls: got %0d expected 16", name, falls); end
        checks++; if (low != 33 * hd(k)) begin errors++; $display("FAIL %s sync_low: got %0d expected %0d", name, low, 33 * hd(k)); end
        checks++; if (dones != 1 || done_at != 33 * hd(k) + 1) begin
            errors++; $display("FAIL %s done: got %0d pulses at %0d expected 1 at %0d", name, dones, done_at, 33 * hd(k) + 1);
        end
        checks++; if (lat != 1 + 33 * hd(k) + gc(k)) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, 1 + 33 * hd(k) + gc(k));
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL %s sclk_while_sync_high: got %0d expected 0", name, stray); end
        if (busy_pulse) begin
            extra_bad = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (sync[k] !== 1'b1 || done[k] !== 1'b0 || ready[k] !== 1'b1) extra_bad++;
            end
            checks++; if (extra_bad != 0) begin errors++; $display("FAIL %s queued_frame: got %0d busy cycles expected 0", name, extra_bad); end
        end
    endtask

    task automatic test_frame_defaults();
        run_frame(0, 8'hA5, 2'b00, 1'b0, 1'b0, "defaults_A5");
    endtask

    task automatic test_half_div1();
        run_frame(1, 8'hFF, 2'b11, 1'b0, 1'b0, "hd1_FF");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 2; k++)
                run_frame(k, 8'($urandom), 2'($urandom), 1'b0, 1'b0, "random");
    endtask

    task automatic test_mid_change();
        run_frame(0, 8'($urandom), 2'($urandom), 1'b0, 1'b1, "mid_change");
        run_frame(1, 8'($urandom), 2'($urandom), 1'b0, 1'b1, "mid_change_hd1");
    endtask

    task automatic test_busy_start();
        run_frame(0, 8'($urandom), 2'($urandom), 1'b1, 1'b0, "busy_start");
    endtask

    // Start held high: frame n must carry code n, each separated by at least GAP_CYC sync-high cycles.
    task automatic test_back_to_back();
        logic [15:0] cap, exp_w;
        logic [1:0] p;
        logic prev_sync, prev_sclk;
        int frames, falls, high_run, min_gap, stray, cyc, in_cyc, bad_words;
        p = 2'($urandom);
        data[0] = 8'h01; pd[0] = p; start[0] = 1'b1;
        frames = 0; falls = 0; high_run = 0; min_gap = 1000; stray = 0; cyc = 0; in_cyc = 0; bad_words = 0;
        cap = '0;
        prev_sync = sync[0]; prev_sclk = sclk[0];
        while (cyc < 400) begin
            step();
            cyc++;
            if (prev_sync === 1'b1 && sync[0] === 1'b0) begin
                frames++;
                if (frames > 1 && high_run < min_gap) min_gap = high_run;
                falls = 0; in_cyc = 0; cap = '0;
            end
            if (sync[0] === 1'b0) begin
                in_cyc++;
                if (prev_sclk === 1'b1 && sclk[0] === 1'b0) begin
                    cap = {cap[14:0], din[0]};
                    falls++;
                end
                if (in_cyc == 10) begin
                    data[0] = 8'(frames + 1);
                    pd[0] = ~p;
                    if (frames == 3) start[0] = 1'b0;
                end
            end else begin
                if (sclk[0] !== prev_sclk) stray++;
                if (prev_sync === 1'b0) begin
                    exp_w = {2'b00, p, 8'(frames), 4'b0000};
                    if (cap !== exp_w || falls != 16) begin
                        bad_words++;
                        $display("FAIL b2b frame%0d: got %h/%0d falls expected %h/16", frames, cap, falls, exp_w);
                    end
                    high_run = 0;
                    pd[0] = p;
                end
                high_run++;
            end
            prev_sync = sync[0];
            prev_sclk = sclk[0];
        end
        start[0] = 1'b0;
        checks++; if (bad_words != 0) begin errors++; $display("FAIL b2b words: got %0d bad expected 0", bad_words); end
        checks++; if (frames != 3) begin errors++; $display("FAIL b2b frames: got %0d expected 3", frames); end
        checks++; if (min_gap < 4) begin errors++; $display("FAIL b2b gap: got %0d expected >=4", min_gap); end
        checks++; if (stray != 0) begin errors++; $display("FAIL b2b sclk_in_gap: got %0d expected 0", stray); end
    endtask

    task automatic test_reset_mid();
        int falls, cyc, bad;
        logic prev_sclk;
        data[0] = 8'($urandom); pd[0] = 2'($urandom); start[0] = 1'b1;
        falls = 0; cyc = 0; bad = 0;
        prev_sclk = sclk[0];
        while (falls < 7 && cyc < 200) begin
            step();
            cyc++;
            start[0] = 1'b0;
            if (sync[0] === 1'b0 && prev_sclk === 1'b1 && sclk[0] === 1'b0) falls++;
            prev_sclk = sclk[0];
        end
        checks++; if (falls != 7) begin errors++; $display("FAIL rst_mid reach: got %0d falls expected 7", falls); end
        rst = 1'b1;
        step();
        check_idle(0, "rst_mid_next");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done[0] !== 1'b0 || sync[0] !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid quiet: got %0d bad cycles expected 0", bad); end
        run_frame(0, 8'($urandom), 2'($urandom), 1'b0, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_frame_defaults();
        test_half_div1();
        test_random();
        test_mid_change();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
